spi_slave_tx: RTL and testbench
===============================

Name: spi_slave_tx

Overview:
SPI slave transmit path that returns data (e.g. recognized digit, status bytes) from the digit recognizer to the external SPI host on MISO. It runs in the system clock domain, synchronizes the host's SCK/SS, and serializes a double-buffered byte LSB-first. SS is asserted low for each byte, with one byte per SS frame. This matches the host framing used on MOSI.

Parameters:
DATA_WIDTH, 8, bits per SS frame
UNDERRUN_WORD, 8'hFF, word shifted out when no data is buffered at frame start
IDLE_MISO, 1'b1, MISO level while SS is high

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
SCK  input  1  SPI serial clock from host, asynchronous to clk, idle low
SS  input  1  SPI slave select from host, asynchronous to clk, active low
tx_data  input  DATA_WIDTH  word to transmit
tx_load  input  1  write strobe for tx_data, accepted only when tx_ready=1
tx_ready  output  1  holding buffer empty
MISO  output  1  serial data to host
tx_busy  output  1  frame in progress
tx_done  output  1  one-clk pulse when a full word has been clocked out
underrun  output  1  one-clk pulse when a frame starts with an empty buffer
aborted  output  1  one-clk pulse when SS rises mid-word

Behaviour:
- Reset (async, n_rst=0): tx_ready=1, MISO=IDLE_MISO, tx_busy=0, tx_done=0, underrun=0, aborted=0. Buffer and shift register are cleared, bit count is 0, and the state is IDLE. Synchronizer flops reset to SCK=0 and SS=1.
- Synchronization: SCK and SS each pass through 2 flops, then a third flop for edge detection. Edge-detect latency is 3 clk. Operation requires an SCK half-period of at least 4 clk cycles.
- Holding buffer:
  - tx_load with tx_ready=1 captures tx_data; tx_ready drops on the next clk.
  - tx_load with tx_ready=0 is ignored, and the buffer is unchanged.
- States:
  - IDLE: on an SS falling edge, the shift register takes the buffer (buffer cleared, tx_ready=1 next clk), bit count=0, and the state goes to SHIFT.
    - If the buffer is empty but tx_load is high in the same clk, tx_data bypasses directly into the shift register with no underrun.
    - If the buffer is empty and tx_load is low, the shift register takes UNDERRUN_WORD and underrun pulses.
  - SHIFT:
    - MISO = shift[0] continuously.
    - On each SCK rising edge, bit count increments.
    - On each SCK falling edge with count<DATA_WIDTH, shift right by 1.
    - When count reaches DATA_WIDTH (after the 8th rising edge), tx_done pulses once and the state goes to DONE.
    - An SS rising edge before count=DATA_WIDTH causes an aborted pulse; the word is discarded and not retried, and the state returns to IDLE.
  - DONE: SCK edges are ignored. On an SS rising edge the state goes to IDLE, with no pulse.
- tx_busy=1 in SHIFT and DONE. MISO=IDLE_MISO in IDLE.
- Bit 0 is valid on MISO within 4 clk of SS falling, before the first SCK rise. Bit n is valid within 4 clk of the n-th SCK falling edge.
- tx_load during SHIFT/DONE fills the buffer for the next frame without disturbing the current word.
- An SS falling edge while not in IDLE cannot occur, because SS must rise first; any such edge is ignored.
- Reset asserted mid-frame returns the block to the reset state immediately. After reset, the next SS fall is treated as a new frame.

Test Plan:
- Reset, tx_load 8'h07, then host frame of 8 SCK (83 ns period, clk 5 ns) -> host samples 8'h07 LSB-first on SCK rising edges; tx_done pulses once; tx_ready=1 after the frame starts.
- Frame with no load -> MISO shifts 8'hFF; underrun pulses once at frame start; tx_done still pulses.
- tx_load 8'hA5, then a second tx_load 8'h3C during that frame -> frame 1 returns 8'hA5; the second load is accepted only once tx_ready=1, and frame 2 returns 8'h3C.
- tx_load 8'h55 while buffer full (holding 8'h12) -> ignored; frame returns 8'h12.
- SS rises after 3 SCK pulses of 8'hC3 -> aborted pulses, no tx_done; MISO=1 in IDLE; next frame with no load underruns.
- n_rst pulsed low mid-frame -> all outputs return to reset values asynchronously; a subsequent loaded frame of 8'h09 transmits correctly.

Source files
------------

// File: rtl/spi_slave_tx_if.sv
// rtl/spi_slave_tx_if.sv - SPI slave transmit bus: host pins plus the local word-load handshake
//
// Signals:
//   SCK, SS   host serial clock and active-low select, asynchronous to clk
//   MISO      serial data back to the host
//   tx_data   word to transmit; tx_load strobe; tx_ready holding buffer empty
//   tx_busy   frame in progress; tx_done / underrun / aborted one-clk status pulses
// Modports: slave is the transmitter block, master is whoever drives it.
interface spi_slave_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  SCK;
  logic                  SS;
  logic                  MISO;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  underrun;
  logic                  aborted;

  modport slave (
    input  SCK, SS, tx_data, tx_load,
    output MISO, tx_ready, tx_busy, tx_done, underrun, aborted
  );

  modport master (
    output SCK, SS, tx_data, tx_load,
    input  MISO, tx_ready, tx_busy, tx_done, underrun, aborted
  );
endinterface

// File: rtl/spi_slave_tx.sv
// rtl/spi_slave_tx.sv - SPI slave transmitter: double-buffered word shifted out LSB-first on MISO
//
// Ports:
//   clk    system clock; SCK and SS are oversampled in this domain
//   n_rst  asynchronous active-low reset
//   bus    spi_slave_tx_if.slave (SCK/SS/MISO plus tx_data/tx_load/tx_ready and status pulses)
// One word per SS-low frame. The holding buffer is moved into the shift register when
// the frame starts, so the next word can be loaded while the current one is on the wire.
module spi_slave_tx #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = {DATA_WIDTH{1'b1}},
  parameter logic                  IDLE_MISO     = 1'b1
) (
  input logic            clk,
  input logic            n_rst,
  spi_slave_tx_if.slave  bus
);

  localparam int                CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Two metastability flops plus one history flop per host signal.
  logic [2:0] sck_sync_q;
  logic [2:0] ss_sync_q;

  state_t                state_q,    state_d;
  logic [DATA_WIDTH-1:0] buf_q,      buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic [CW-1:0]         cnt_q,      cnt_d;
  logic                  miso_q,     miso_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  underrun_q, underrun_d;
  logic                  aborted_q,  aborted_d;

  logic sck_rise, sck_fall, ss_rise, ss_fall;

  assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] &  sck_sync_q[2];
  assign ss_rise  =  ss_sync_q[1]  & ~ss_sync_q[2];
  assign ss_fall  = ~ss_sync_q[1]  &  ss_sync_q[2];

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    aborted_d  = 1'b0;

    // A load is only taken while the buffer is empty; otherwise it is dropped.
    if (bus.tx_load && !buf_full_q) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_d      = '0;
            buf_full_d = 1'b0;
          end else if (bus.tx_load) begin
            // Word arriving in the same clk as the frame start goes straight to the
            // shift register; the buffer stays empty for the next frame.
            shift_d    = bus.tx_data;
            buf_d      = buf_q;
            buf_full_d = 1'b0;
          end else begin
            shift_d    = UNDERRUN_WORD;
            underrun_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          // Host gave up mid-word: drop it, no retry.
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          if (sck_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CNT_FULL) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
          if (sck_fall && cnt_q < CNT_FULL) begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
          end
        end
      end
      ST_DONE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    miso_d = busy_d ? shift_d[0] : IDLE_MISO;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync_q <= 3'b000;
      ss_sync_q  <= 3'b111;
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      miso_q     <= IDLE_MISO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], bus.SCK};
      ss_sync_q  <= {ss_sync_q[1:0], bus.SS};
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.tx_ready = ~buf_full_q;
  assign bus.MISO     = miso_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.underrun = underrun_q;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// tb/tb_spi_slave_tx.sv - self-checking bench for spi_slave_tx
`timescale 1ns/1ps
module tb_spi_slave_tx;

  logic clk;
  logic n_rst;

  spi_slave_tx_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_tx #(
    .DATA_WIDTH   (8),
    .UNDERRUN_WORD(8'hFF),
    .IDLE_MISO    (1'b1)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  int checks;
  int failures;
  int n_done;
  int n_under;
  int n_abort;

  always @(negedge clk) begin
    if (bus.tx_done === 1'b1)  n_done++;
    if (bus.underrun === 1'b1) n_under++;
    if (bus.aborted === 1'b1)  n_abort++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  // Host side of one frame: bits are sampled just before each SCK rise.
  task automatic run_frame(input int nsck, input bit mid_ld, input logic [7:0] dm,
                           output logic [7:0] rx, output logic busy_seen);
    rx = 8'h00;
    busy_seen = 1'b0;
    @(negedge clk);
    bus.SS = 1'b0;
    #60;
    busy_seen = bus.tx_busy;
    for (int i = 0; i < nsck; i++) begin
      rx[i] = bus.MISO;
      bus.SCK = 1'b1;
      if (i == 0 && mid_ld) begin
        chk("ready_before_mid_load", {31'd0, bus.tx_ready}, 32'd1);
        do_load(dm);
      end
      #41.5;
      bus.SCK = 1'b0;
      #41.5;
    end
    #60;
    bus.SS = 1'b1;
    #60;
  endtask

  typedef struct {
    bit         ld0;
    logic [7:0] d0;
    bit         ld1;
    logic [7:0] d1;
    bit         mid_ld;
    logic [7:0] dm;
    int         nsck;
    logic [7:0] exp_rx;
    int         exp_done;
    int         exp_under;
    int         exp_abort;
  } vec_t;

  vec_t vecs[7];

  logic [7:0] model_q[$];

  initial begin
    logic [7:0] rx;
    logic       busy;
    int         sd, su, sa;
    logic [7:0] mask;
    logic [7:0] exp;
    int         exp_u;
    int         nsck;
    bit         mid;
    logic [7:0] d;

    checks = 0; failures = 0;
    n_done = 0; n_under = 0; n_abort = 0;
    n_rst = 1'b0;
    bus.SCK = 1'b0;
    bus.SS = 1'b1;
    bus.tx_load = 1'b0;
    bus.tx_data = 8'h00;

    //           ld0  d0     ld1  d1     mid  dm     nsck rx     done und ab
    vecs[0] = '{1'b1, 8'h07, 1'b0, 8'h00, 1'b0, 8'h00, 8, 8'h07, 1, 0, 0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8, 8'hFF, 1, 1, 0};
    vecs[2] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 8'h3C, 8, 8'hA5, 1, 0, 0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8, 8'h3C, 1, 0, 0};
    vecs[4] = '{1'b1, 8'h12, 1'b1, 8'h55, 1'b0, 8'h00, 8, 8'h12, 1, 0, 0};
    vecs[5] = '{1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00, 3, 8'h03, 0, 0, 1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8, 8'hFF, 1, 1, 0};

    #12;
    chk("rst_ready",    {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_miso",     {31'd0, bus.MISO},     32'd1);
    chk("rst_busy",     {31'd0, bus.tx_busy},  32'd0);
    chk("rst_done",     {31'd0, bus.tx_done},  32'd0);
    chk("rst_underrun", {31'd0, bus.underrun}, 32'd0);
    chk("rst_aborted",  {31'd0, bus.aborted},  32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    #20;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].ld0) do_load(vecs[v].d0);
      if (vecs[v].ld1) begin
        chk($sformatf("v%0d_ready_full", v), {31'd0, bus.tx_ready}, 32'd0);
        do_load(vecs[v].d1);
      end
      sd = n_done; su = n_under; sa = n_abort;
      run_frame(vecs[v].nsck, vecs[v].mid_ld, vecs[v].dm, rx, busy);
      mask = 8'((1 << vecs[v].nsck) - 1);
      chk($sformatf("v%0d_rx", v),       {24'd0, rx & mask}, {24'd0, vecs[v].exp_rx});
      chk($sformatf("v%0d_busy", v),     {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_done", v),     n_done - sd,  vecs[v].exp_done);
      chk($sformatf("v%0d_underrun", v), n_under - su, vecs[v].exp_under);
      chk($sformatf("v%0d_aborted", v),  n_abort - sa, vecs[v].exp_abort);
      chk($sformatf("v%0d_idle_miso", v), {31'd0, bus.MISO}, 32'd1);
      chk($sformatf("v%0d_idle_busy", v), {31'd0, bus.tx_busy}, 32'd0);
      chk($sformatf("v%0d_ready", v), {31'd0, bus.tx_ready}, {31'd0, !vecs[v].mid_ld});
    end

    // Bypass: tx_load lands in the same clk the frame start is acted on.
    sd = n_done; su = n_under;
    @(negedge clk);
    bus.SS = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.tx_data = 8'h6B;
    bus.tx_load = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_load = 1'b0;
    #50;
    rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rx[i] = bus.MISO;
      bus.SCK = 1'b1; #41.5;
      bus.SCK = 1'b0; #41.5;
    end
    #60; bus.SS = 1'b1; #60;
    chk("bypass_rx",       {24'd0, rx}, 32'h6B);
    chk("bypass_underrun", n_under - su, 0);
    chk("bypass_done",     n_done - sd, 1);
    chk("bypass_ready",    {31'd0, bus.tx_ready}, 32'd1);

    // Asynchronous reset in the middle of a frame.
    do_load(8'h5A);
    @(negedge clk);
    bus.SS = 1'b0;
    #60;
    for (int i = 0; i < 3; i++) begin
      bus.SCK = 1'b1; #41.5;
      bus.SCK = 1'b0; #41.5;
    end
    sa = n_abort;
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk("midrst_ready",    {31'd0, bus.tx_ready}, 32'd1);
    chk("midrst_miso",     {31'd0, bus.MISO},     32'd1);
    chk("midrst_busy",     {31'd0, bus.tx_busy},  32'd0);
    chk("midrst_done",     {31'd0, bus.tx_done},  32'd0);
    chk("midrst_underrun", {31'd0, bus.underrun}, 32'd0);
    chk("midrst_aborted",  {31'd0, bus.aborted},  32'd0);
    bus.SS = 1'b1;
    bus.SCK = 1'b0;
    #20;
    @(negedge clk);
    n_rst = 1'b1;
    #40;
    do_load(8'h09);
    sd = n_done; su = n_under;
    run_frame(8, 1'b0, 8'h00, rx, busy);
    chk("postrst_rx",       {24'd0, rx}, 32'h09);
    chk("postrst_done",     n_done - sd, 1);
    chk("postrst_underrun", n_under - su, 0);
    chk("postrst_aborted",  n_abort - sa, 0);

    // Randomized frames against a one-entry buffer model.
    model_q.delete();
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          d = 8'($urandom);
          chk($sformatf("r%0d_ready_pre", it), {31'd0, bus.tx_ready},
              {31'd0, model_q.size() == 0});
          if (model_q.size() == 0) model_q.push_back(d);
          do_load(d);
        end
      end
      if (model_q.size() != 0) begin
        exp = model_q.pop_front();
        exp_u = 0;
      end else begin
        exp = 8'hFF;
        exp_u = 1;
      end
      nsck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      mid = ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      if (mid) model_q.push_back(d);
      sd = n_done; su = n_under; sa = n_abort;
      run_frame(nsck, mid, d, rx, busy);
      mask = 8'((1 << nsck) - 1);
      chk($sformatf("r%0d_rx", it),       {24'd0, rx & mask}, {24'd0, exp & mask});
      chk($sformatf("r%0d_done", it),     n_done - sd,  (nsck == 8) ? 1 : 0);
      chk($sformatf("r%0d_aborted", it),  n_abort - sa, (nsck == 8) ? 0 : 1);
      chk($sformatf("r%0d_underrun", it), n_under - su, exp_u);
      chk($sformatf("r%0d_idle_miso", it), {31'd0, bus.MISO}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
